// File: rtl/rstgen_seq.sv
// Reset sequencer: holds every channel in reset for a minimum width, then releases
// them one at a time in ascending order; supports software re-reset and test bypass.
module rstgen_seq #(
  parameter int unsigned NumChannels = 4,
  parameter int unsigned MinPulse    = 16,
  parameter int unsigned DelayCycles = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   test_mode_i,
  input  logic                   rst_test_mode_ni,
  input  logic                   sw_req_valid_i,
  input  logic [NumChannels-1:0] sw_req_mask_i,
  output logic                   sw_req_ready_o,
  output logic [NumChannels-1:0] rst_no,
  output logic [NumChannels-1:0] init_no,
  output logic                   busy_o,
  output logic                   done_o
);

  if (NumChannels < 1) begin : g_bad_channels
    $fatal(1, "rstgen_seq: NumChannels must be >= 1");
  end
  if (MinPulse < 1) begin : g_bad_pulse
    $fatal(1, "rstgen_seq: MinPulse must be >= 1");
  end
  if (DelayCycles < 1) begin : g_bad_delay
    $fatal(1, "rstgen_seq: DelayCycles must be >= 1");
  end

  localparam int unsigned MaxCnt = (MinPulse > DelayCycles) ? MinPulse : DelayCycles;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);
  localparam logic [CntW-1:0] PulseLast = CntW'(MinPulse - 1);
  localparam logic [CntW-1:0] DelayLast = CntW'(DelayCycles - 1);

  localparam logic [1:0] S_RESET   = 2'd0;
  localparam logic [1:0] S_HOLD    = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;
  localparam logic [1:0] S_RUN     = 2'd3;

  logic                   irst_n;
  logic [1:0]             state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [NumChannels-1:0] rst_q, rst_d;
  logic [NumChannels-1:0] act_q, act_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
  logic                   ready_q, ready_d;
  logic [NumChannels-1:0] pend, low;
  logic                   last, accept;

  assign irst_n = test_mode_i ? rst_test_mode_ni : rst_ni;

  // State register; internal reset aborts any sequence in progress
  always_ff @(posedge clk_i) begin
    if (!irst_n) begin
      state_q <= S_RESET;
      cnt_q   <= '0;
      rst_q   <= '0;
      act_q   <= '1;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
      act_q   <= act_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  // Channels still held low within the active set; the lowest one goes next
  assign pend   = act_q & ~rst_q;
  assign low    = pend & (~pend + NumChannels'(1));
  assign last   = ((pend & ~low) == '0);
  assign accept = sw_req_valid_i & sw_req_ready_o;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rst_d   = rst_q;
    act_d   = act_q;
    done_d  = 1'b0;
    case (state_q)
      S_RESET: begin
        state_d = S_HOLD;
        cnt_d   = '0;
      end
      S_HOLD, S_RELEASE: begin
        if (cnt_q == ((state_q == S_HOLD) ? PulseLast : DelayLast)) begin
          rst_d = rst_q | low;
          cnt_d = '0;
          if (last) begin
            state_d = S_RUN;
            done_d  = 1'b1;
          end else begin
            state_d = S_RELEASE;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        if (accept) begin
          if (sw_req_mask_i != '0) begin
            act_d   = sw_req_mask_i;
            rst_d   = rst_q & ~sw_req_mask_i;
            cnt_d   = '0;
            state_d = S_HOLD;
          end else begin
            done_d = 1'b1;
          end
        end
      end
    endcase
    busy_d  = (state_d != S_RUN);
    ready_d = (state_d == S_RUN);
  end

  // Test mode bypasses the sequencer outputs; the sequencer itself keeps running
  assign rst_no         = test_mode_i ? {NumChannels{rst_test_mode_ni}} : rst_q;
  assign init_no        = test_mode_i ? '1 : rst_q;
  assign sw_req_ready_o = ready_q & ~test_mode_i;
  assign busy_o         = busy_q;
  assign done_o         = done_q;

endmodule

// File: tb/tb_rstgen_seq.sv
// Bench for rstgen_seq: directed tables for the documented sequences plus random
// traffic checked against a release-schedule model.
module tb_rstgen_seq;

  localparam int unsigned MP = 16;
  localparam int unsigned DC = 4;

  typedef struct {
    int         edge_n;
    logic [3:0] rst;
    logic       busy;
    logic       done;
    logic       rdy;
  } vec_t;

  logic       clk;
  logic       rst_ni, test_mode, rst_tm_n, valid;
  logic [3:0] mask;
  logic       ready, busy, done;
  logic [3:0] rst_out, init_out;

  logic       rst_s, valid_s, tm_s, rtm_s;
  logic [0:0] mask_s, rst_out_s, init_out_s;
  logic       ready_s, busy_s, done_s;

  int checks = 0;
  int failures = 0;

  rstgen_seq #(.NumChannels(4), .MinPulse(MP), .DelayCycles(DC)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .test_mode_i(test_mode), .rst_test_mode_ni(rst_tm_n),
    .sw_req_valid_i(valid), .sw_req_mask_i(mask), .sw_req_ready_o(ready),
    .rst_no(rst_out), .init_no(init_out), .busy_o(busy), .done_o(done)
  );

  rstgen_seq #(.NumChannels(1), .MinPulse(1), .DelayCycles(1)) dut_s (
    .clk_i(clk), .rst_ni(rst_s), .test_mode_i(tm_s), .rst_test_mode_ni(rtm_s),
    .sw_req_valid_i(valid_s), .sw_req_mask_i(mask_s), .sw_req_ready_o(ready_s),
    .rst_no(rst_out_s), .init_no(init_out_s), .busy_o(busy_s), .done_o(done_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: each sequence is a list of absolute release times
  int unsigned cyc;
  int unsigned rel[4];
  logic [3:0]  m_rst, m_pend;
  logic        m_inreset, m_busy, m_done, m_rdy;

  task automatic sched(input logic [3:0] msk);
    int unsigned k = 0;
    for (int i = 0; i < 4; i++) begin
      if (msk[i]) begin
        rel[i] = cyc + MP + k * DC;
        k++;
      end
    end
    m_pend = msk;
  endtask

  task automatic model_step();
    logic irst;
    cyc++;
    irst = test_mode ? rst_tm_n : rst_ni;
    if (!irst) begin
      m_inreset = 1'b1; m_rst = '0; m_pend = '0;
      m_busy = 1'b1; m_done = 1'b0; m_rdy = 1'b0;
    end else if (m_inreset) begin
      m_inreset = 1'b0;
      sched(4'hF);
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        for (int i = 0; i < 4; i++) begin
          if (m_pend[i] && rel[i] == cyc) begin
            m_rst[i] = 1'b1;
            m_pend[i] = 1'b0;
          end
        end
        if (m_pend == '0) begin
          m_busy = 1'b0; m_done = 1'b1; m_rdy = 1'b1;
        end
      end else if (valid && m_rdy && !test_mode) begin
        if (mask != '0) begin
          m_rst = m_rst & ~mask;
          sched(mask);
          m_busy = 1'b1; m_rdy = 1'b0;
        end else begin
          m_done = 1'b1;
        end
      end
    end
  endtask

  initial begin
    cyc = 0; m_inreset = 1'b1; m_rst = '0; m_pend = '0;
    m_busy = 1'b1; m_done = 1'b0; m_rdy = 1'b0;
    for (int i = 0; i < 4; i++) rel[i] = 0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_main();
    chk("m_rst_no", 32'(rst_out), 32'(test_mode ? {4{rst_tm_n}} : m_rst));
    chk("m_init_no", 32'(init_out), 32'(test_mode ? 4'hF : m_rst));
    chk("m_busy", 32'(busy), 32'(m_busy));
    chk("m_done", 32'(done), 32'(m_done));
    chk("m_ready", 32'(ready), 32'(m_rdy & ~test_mode));
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    check_main();
  endtask

  task automatic apply(input string tag, input vec_t v, inout int e);
    while (e < v.edge_n) begin
      step();
      e++;
    end
    chk($sformatf("%s_rst@%0d", tag, e), 32'(rst_out), 32'(v.rst));
    chk($sformatf("%s_busy@%0d", tag, e), 32'(busy), 32'(v.busy));
    chk($sformatf("%s_done@%0d", tag, e), 32'(done), 32'(v.done));
    chk($sformatf("%s_ready@%0d", tag, e), 32'(ready), 32'(v.rdy));
  endtask

  vec_t pon[9];
  vec_t rer[6];
  int   e;

  initial begin
    pon[0] = '{0,  4'b0000, 1'b1, 1'b0, 1'b0};
    pon[1] = '{15, 4'b0000, 1'b1, 1'b0, 1'b0};
    pon[2] = '{16, 4'b0001, 1'b1, 1'b0, 1'b0};
    pon[3] = '{19, 4'b0001, 1'b1, 1'b0, 1'b0};
    pon[4] = '{20, 4'b0011, 1'b1, 1'b0, 1'b0};
    pon[5] = '{24, 4'b0111, 1'b1, 1'b0, 1'b0};
    pon[6] = '{27, 4'b0111, 1'b1, 1'b0, 1'b0};
    pon[7] = '{28, 4'b1111, 1'b0, 1'b1, 1'b1};
    pon[8] = '{29, 4'b1111, 1'b0, 1'b0, 1'b1};
    rer[0] = '{0,  4'b0101, 1'b1, 1'b0, 1'b0};
    rer[1] = '{15, 4'b0101, 1'b1, 1'b0, 1'b0};
    rer[2] = '{16, 4'b0111, 1'b1, 1'b0, 1'b0};
    rer[3] = '{19, 4'b0111, 1'b1, 1'b0, 1'b0};
    rer[4] = '{20, 4'b1111, 1'b0, 1'b1, 1'b1};
    rer[5] = '{21, 4'b1111, 1'b0, 1'b0, 1'b1};

    rst_ni = 1'b0; test_mode = 1'b0; rst_tm_n = 1'b1; valid = 1'b0; mask = '0;
    rst_s = 1'b0; tm_s = 1'b0; rtm_s = 1'b1; valid_s = 1'b0; mask_s = '0;

    // Reset values
    repeat (3) step();
    chk("rst_rst_no", 32'(rst_out), 32'(4'h0));
    chk("rst_init_no", 32'(init_out), 32'(4'h0));
    chk("rst_busy", 32'(busy), 32'(1));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_ready", 32'(ready), 32'(0));

    // Power-on release schedule
    rst_ni = 1'b1;
    e = -1;
    foreach (pon[i]) apply("pon", pon[i], e);

    // Software re-reset of channels 1 and 3
    valid = 1'b1; mask = 4'b1010;
    e = -1;
    foreach (rer[i]) begin
      apply("rer", rer[i], e);
      valid = 1'b0;
    end

    // Zero-mask request: done pulse only
    valid = 1'b1; mask = 4'b0000;
    step();
    chk("zm_rst", 32'(rst_out), 32'(4'hF));
    chk("zm_done", 32'(done), 32'(1));
    chk("zm_busy", 32'(busy), 32'(0));
    valid = 1'b0;
    step();
    chk("zm_done_end", 32'(done), 32'(0));
    chk("zm_ready", 32'(ready), 32'(1));

    // Reset mid-sequence aborts, then the full schedule restarts
    rst_ni = 1'b0;
    repeat (2) step();
    rst_ni = 1'b1;
    e = -1;
    while (e < 21) begin
      step();
      e++;
    end
    rst_ni = 1'b0;
    step();
    chk("abort_rst", 32'(rst_out), 32'(4'h0));
    chk("abort_busy", 32'(busy), 32'(1));
    chk("abort_done", 32'(done), 32'(0));
    repeat (2) step();
    rst_ni = 1'b1;
    e = -1;
    foreach (pon[i]) apply("pon2", pon[i], e);

    // Test mode bypass follows the test reset combinationally
    test_mode = 1'b1; rst_tm_n = 1'b1;
    #1;
    chk("tm_rst_hi", 32'(rst_out), 32'(4'hF));
    chk("tm_init", 32'(init_out), 32'(4'hF));
    chk("tm_ready", 32'(ready), 32'(0));
    rst_tm_n = 1'b0;
    #1;
    chk("tm_rst_lo", 32'(rst_out), 32'(4'h0));
    chk("tm_init_lo", 32'(init_out), 32'(4'hF));
    rst_tm_n = 1'b1;
    #1;
    chk("tm_rst_hi2", 32'(rst_out), 32'(4'hF));
    repeat (3) step();
    rst_tm_n = 1'b0;
    repeat (2) step();
    rst_tm_n = 1'b1;
    repeat (10) step();
    test_mode = 1'b0;
    repeat (30) step();
    chk("tm_resume_rst", 32'(rst_out), 32'(4'hF));
    chk("tm_resume_busy", 32'(busy), 32'(0));

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst_ni = ($urandom_range(0, 99) >= 2);
      valid = ($urandom_range(0, 3) == 0);
      mask = 4'($urandom);
      if ($urandom_range(0, 99) == 0) test_mode = ~test_mode;
      rst_tm_n = ($urandom_range(0, 9) != 0);
      step();
    end
    rst_ni = 1'b1; test_mode = 1'b0; rst_tm_n = 1'b1; valid = 1'b0;

    // Single channel, minimal timing; request held while busy
    @(negedge clk);
    chk("s_reset_rst", 32'(rst_out_s), 32'(0));
    chk("s_reset_init", 32'(init_out_s), 32'(0));
    chk("s_reset_busy", 32'(busy_s), 32'(1));
    rst_s = 1'b1; valid_s = 1'b1; mask_s = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("s_e0_rst", 32'(rst_out_s), 32'(0));
    chk("s_e0_ready", 32'(ready_s), 32'(0));
    @(posedge clk); @(negedge clk);
    chk("s_e1_rst", 32'(rst_out_s), 32'(1));
    chk("s_e1_done", 32'(done_s), 32'(1));
    chk("s_e1_busy", 32'(busy_s), 32'(0));
    chk("s_e1_ready", 32'(ready_s), 32'(1));
    @(posedge clk); @(negedge clk);
    chk("s_e2_rst", 32'(rst_out_s), 32'(0));
    chk("s_e2_busy", 32'(busy_s), 32'(1));
    chk("s_e2_done", 32'(done_s), 32'(0));
    @(posedge clk); @(negedge clk);
    valid_s = 1'b0;
    chk("s_e3_rst", 32'(rst_out_s), 32'(1));
    chk("s_e3_done", 32'(done_s), 32'(1));
    @(posedge clk); @(negedge clk);
    chk("s_e4_done", 32'(done_s), 32'(0));
    chk("s_e4_rst", 32'(rst_out_s), 32'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
